// File: rtl/ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the two-master RAM arbiter.
//   arb_state_e    : owner of the previous cycle (IDLE / OWN0 / OWN1)
//   M0, M1         : master indices, also the encoding of the round-robin pointer
//   RAM_DEPTH_DEF  : default RAM depth in 32-bit words
//   word_index()   : byte address -> RAM word index
// -----------------------------------------------------------------------------
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int unsigned RAM_DEPTH_DEF = 4096;

   // The RAM is word-addressed; the two low byte-address bits select a byte
   // lane inside a word and never reach the RAM index.
   function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
      return {2'b00, byte_addr[31:2]};
   endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// -----------------------------------------------------------------------------
// ram_arb_rr
// Grant decision for the two-master RAM arbiter: round-robin between the two
// masters, with a burst counter that limits how many consecutive beats one
// master may take while the other one is waiting.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   req0_i  in   master 0 request
//   req1_i  in   master 1 request
//   gnt0_o  out  master 0 granted this cycle (combinational)
//   gnt1_o  out  master 1 granted this cycle (combinational)
// -----------------------------------------------------------------------------
module ram_arb_rr
   import ram_arb_pkg::*;
#(
   parameter int unsigned BURST_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   arb_state_e       state_q,     state_d;
   logic             rr_ptr_q,    rr_ptr_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   // NOTE: every signal written in an always_comb block gets a default value
   // first, so no path through the block can leave it unassigned (latch).
   always_comb begin
      gnt0_o      = 1'b0;
      gnt1_o      = 1'b0;
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;

      unique case (state_q)
         IDLE: begin
            // Contention from idle is settled by the round-robin pointer.
            if (req0_i && (!req1_i || rr_ptr_q == M0)) gnt0_o = 1'b1;
            else if (req1_i)                            gnt1_o = 1'b1;
         end
         OWN0: begin
            // The owner keeps the RAM until it has used its burst allowance
            // and only if the other master is actually waiting.
            if (req0_i && (!req1_i || burst_cnt_q < CNT_MAX)) gnt0_o = 1'b1;
            else if (req1_i)                                   gnt1_o = 1'b1;
         end
         OWN1: begin
            if (req1_i && (!req0_i || burst_cnt_q < CNT_MAX)) gnt1_o = 1'b1;
            else if (req0_i)                                   gnt0_o = 1'b1;
         end
         default: ;
      endcase

      if (gnt0_o) begin
         state_d     = OWN0;
         rr_ptr_d    = M1;
         burst_cnt_d = (state_q != OWN0)        ? CNT_ONE :
                       (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CNT_ONE;
      end else if (gnt1_o) begin
         state_d     = OWN1;
         rr_ptr_d    = M0;
         burst_cnt_d = (state_q != OWN1)        ? CNT_ONE :
                       (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CNT_ONE;
      end else begin
         state_d     = IDLE;
         burst_cnt_d = '0;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= M0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port word RAM (synchronous write, combinational read)
// between m0 (core load/store unit) and m1 (debug/DMA loader). The grant is
// combinational; the read response is registered and returned one cycle after
// the access is accepted.
//
// Optional feature, enabled by defining RAM_ARB_ADDR_CHECK_EN:
//   accesses with word index >= DEPTH or a non-word-aligned address are still
//   granted, but the RAM write is suppressed, mx_err_o pulses the next cycle
//   and reads return rvalid with zero data. Without the macro the err outputs
//   stay 0 and addresses reach the RAM unmodified.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mx_req_i / mx_we_i       request and write enable of master x (x = 0,1)
//   mx_addr_i / mx_wdata_i   byte address and write data of master x
//   mx_gnt_o                 master x accepted this cycle
//   mx_rvalid_o / mx_rdata_o read response of master x (one-cycle pulse)
//   mx_err_o                 address error of master x
//   ram_we_o / ram_addr_o / ram_wdata_o   RAM write enable, byte address, data
//   ram_rdata_i              RAM combinational read data for ram_addr_o
// -----------------------------------------------------------------------------
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = RAM_DEPTH_DEF,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_err_o,

   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_err_o,

   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

`ifdef RAM_ARB_ADDR_CHECK_EN
   localparam logic ADDR_CHECK_EN = 1'b1;
`else
   localparam logic ADDR_CHECK_EN = 1'b0;
`endif

   logic              gnt0, gnt1, any_gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              addr_bad;

   logic [ADDR_W-1:0] last_addr_q;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic              err0_q,    err0_d,    err1_q,    err1_d;
   logic [DATA_W-1:0] rdata0_q,  rdata0_d,  rdata1_q,  rdata1_d;

   ram_arb_rr #(
      .BURST_MAX (BURST_MAX)
   ) u_rr (
      .clk    (clk),
      .rst    (rst),
      .req0_i (m0_req_i),
      .req1_i (m1_req_i),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1)
   );

   assign any_gnt   = gnt0 | gnt1;
   assign sel_we    = gnt1 ? m1_we_i    : m0_we_i;
   assign sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
   assign sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

   // With the check compiled out ADDR_CHECK_EN is a constant 0 and the whole
   // term folds away.
   assign addr_bad = ADDR_CHECK_EN & any_gnt &
                     ((word_index(32'(sel_addr)) >= DEPTH) || (sel_addr[1:0] != 2'b00));

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;

   assign ram_we_o    = any_gnt & sel_we & ~addr_bad;
   // Holding the last granted address keeps the RAM read port quiet while
   // nobody is using it.
   assign ram_addr_o  = any_gnt ? sel_addr : last_addr_q;
   assign ram_wdata_o = sel_wdata;

   always_comb begin
      rvalid0_d = gnt0 & ~m0_we_i;
      rvalid1_d = gnt1 & ~m1_we_i;
      err0_d    = gnt0 & addr_bad;
      err1_d    = gnt1 & addr_bad;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      if (rvalid0_d) rdata0_d = addr_bad ? '0 : ram_rdata_i;
      if (rvalid1_d) rdata1_d = addr_bad ? '0 : ram_rdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_addr_q <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         if (any_gnt) last_addr_q <= sel_addr;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign m0_rvalid_o = rvalid0_q;
   assign m1_rvalid_o = rvalid1_q;
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;
   assign m0_err_o    = err0_q;
   assign m1_err_o    = err1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural 4096 x 32 RAM attached
// (synchronous write, combinational read). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;

   int checks   = 0;
   int failures = 0;

   ram_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .DEPTH     (4096),
      .BURST_MAX (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m0_req_i    (m0_req),
      .m0_we_i     (m0_we),
      .m0_addr_i   (m0_addr),
      .m0_wdata_i  (m0_wdata),
      .m0_gnt_o    (m0_gnt),
      .m0_rvalid_o (m0_rvalid),
      .m0_rdata_o  (m0_rdata),
      .m0_err_o    (m0_err),
      .m1_req_i    (m1_req),
      .m1_we_i     (m1_we),
      .m1_addr_i   (m1_addr),
      .m1_wdata_i  (m1_wdata),
      .m1_gnt_o    (m1_gnt),
      .m1_rvalid_o (m1_rvalid),
      .m1_rdata_o  (m1_rdata),
      .m1_err_o    (m1_err),
      .ram_we_o    (ram_we),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata)
   );

   // Behavioural RAM
   logic [31:0] mem [0:4095];
   always @(posedge clk) if (ram_we) mem[ram_addr[13:2]] <= ram_wdata;
   assign ram_rdata = mem[ram_addr[13:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Requester obligation: once requesting, hold req/we/addr/wdata until gnt.
   logic        w0, w1;
   logic [64:0] s0, s1;
   always @(negedge clk) begin
      if (rst) begin
         w0 <= 1'b0;
         w1 <= 1'b0;
      end else begin
         if (w0) assert (m0_req && {m0_we, m0_addr, m0_wdata} == s0)
            else $error("m0 request dropped or changed before its grant");
         if (w1) assert (m1_req && {m1_we, m1_addr, m1_wdata} == s1)
            else $error("m1 request dropped or changed before its grant");
         w0 <= m0_req & ~m0_gnt;
         w1 <= m1_req & ~m1_gnt;
         s0 <= {m0_we, m0_addr, m0_wdata};
         s1 <= {m1_we, m1_addr, m1_wdata};
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
   endtask

   task automatic do_reset();
      drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic exp_g0, prev_g0, prev_g1;

   initial begin
      drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      do_reset();

      // ---------------- reset state ----------------
      mid();
      check("rst_gnt0",    m0_gnt,    0);
      check("rst_gnt1",    m1_gnt,    0);
      check("rst_rvalid0", m0_rvalid, 0);
      check("rst_rvalid1", m1_rvalid, 0);
      check("rst_rdata0",  m0_rdata,  0);
      check("rst_rdata1",  m1_rdata,  0);
      check("rst_err0",    m0_err,    0);
      check("rst_err1",    m1_err,    0);
      check("rst_ram_we",  ram_we,    0);

      // ---------------- m0 write then read ----------------
      tick(); drive_m0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      mid();
      check("wr_gnt0",     m0_gnt,    1);
      check("wr_gnt1",     m1_gnt,    0);
      check("wr_ram_we",   ram_we,    1);
      check("wr_ram_addr", ram_addr,  32'h10);
      check("wr_ram_data", ram_wdata, 32'hDEADBEEF);
      tick(); drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      mid();
      check("rd_gnt0",     m0_gnt,    1);
      check("rd_ram_we",   ram_we,    0);
      check("wr_no_rvalid", m0_rvalid, 0);
      tick(); drive_m0(1'b0, 1'b0, 32'h44, 32'h0);
      mid();
      check("rd_rvalid0",  m0_rvalid, 1);
      check("rd_rdata0",   m0_rdata,  32'hDEADBEEF);
      check("rd_err0",     m0_err,    0);
      check("rd_rvalid1",  m1_rvalid, 0);
      check("rd_rdata1",   m1_rdata,  0);
      check("idle_gnt0",   m0_gnt,    0);
      check("idle_we",     ram_we,    0);
      check("idle_addr_hold", ram_addr, 32'h10);
      tick();
      mid();
      check("rvalid_pulse", m0_rvalid, 0);
      check("rdata_hold",   m0_rdata,  32'hDEADBEEF);

      // ---------------- simultaneous requests from IDLE ----------------
      tick(); do_reset();
      drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      drive_m1(1'b1, 1'b0, 32'h10, 32'h0);
      mid();
      check("sim1_gnt0", m0_gnt, 1);
      check("sim1_gnt1", m1_gnt, 0);
      tick(); drive_m0(1'b0, 1'b0, 32'h10, 32'h0);
      mid();
      check("sim1_m1_gnt1", m1_gnt, 1);
      check("sim1_m1_gnt0", m0_gnt, 0);
      tick(); drive_m1(1'b0, 1'b0, 32'h10, 32'h0);
      mid();
      check("sim1_m1_rvalid", m1_rvalid, 1);
      check("sim1_m1_rdata",  m1_rdata,  32'hDEADBEEF);
      tick(); drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      mid();
      check("solo_gnt0", m0_gnt, 1);
      tick(); drive_m0(1'b0, 1'b0, 32'h10, 32'h0);
      tick();
      drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      drive_m1(1'b1, 1'b0, 32'h10, 32'h0);
      mid();
      check("sim2_gnt1", m1_gnt, 1);
      check("sim2_gnt0", m0_gnt, 0);
      tick(); drive_m1(1'b0, 1'b0, 32'h10, 32'h0);
      mid();
      check("sim2_m0_gnt0", m0_gnt, 1);
      tick(); drive_m0(1'b0, 1'b0, 32'h10, 32'h0);

      // ---------------- write m0 then read m1 next cycle ----------------
      tick(); drive_m0(1'b1, 1'b1, 32'h20, 32'h1);
      mid();
      check("x_wr_gnt0", m0_gnt, 1);
      tick();
      drive_m0(1'b0, 1'b0, 32'h20, 32'h0);
      drive_m1(1'b1, 1'b0, 32'h20, 32'h0);
      mid();
      check("x_rd_gnt1", m1_gnt, 1);
      tick(); drive_m1(1'b0, 1'b0, 32'h20, 32'h0);
      mid();
      check("x_rd_rvalid1", m1_rvalid, 1);
      check("x_rd_rdata1",  m1_rdata,  32'h1);

      // ---------------- continuous contention, BURST_MAX = 4 ----------------
      tick();
      drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      drive_m1(1'b1, 1'b0, 32'h20, 32'h0);
      prev_g0 = 1'b0;
      prev_g1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp_g0 = (i < 4) || (i >= 8);
         mid();
         check($sformatf("burst%0d_gnt0", i), m0_gnt, exp_g0);
         check($sformatf("burst%0d_gnt1", i), m1_gnt, !exp_g0);
         check($sformatf("burst%0d_rvalid0", i), m0_rvalid, prev_g0);
         check($sformatf("burst%0d_rvalid1", i), m1_rvalid, prev_g1);
         if (prev_g0) check($sformatf("burst%0d_rdata0", i), m0_rdata, 32'hDEADBEEF);
         if (prev_g1) check($sformatf("burst%0d_rdata1", i), m1_rdata, 32'h1);
         prev_g0 = exp_g0;
         prev_g1 = !exp_g0;
         tick();
      end
      drive_m0(1'b0, 1'b0, 32'h10, 32'h0);
      mid();
      check("burst_end_gnt1",    m1_gnt,    1);
      check("burst_end_rvalid0", m0_rvalid, 1);
      tick(); drive_m1(1'b0, 1'b0, 32'h20, 32'h0);
      mid();
      check("burst_end_rvalid1", m1_rvalid, 1);
      check("burst_end_rdata1",  m1_rdata,  32'h1);

      // ---------------- reset right after a read grant ----------------
      tick(); drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      mid();
      check("rstmid_gnt0", m0_gnt, 1);
      rst = 1'b1;
      tick(); drive_m0(1'b0, 1'b0, 32'h10, 32'h0);
      mid();
      check("rstmid_rvalid0_a", m0_rvalid, 0);
      check("rstmid_rdata0",    m0_rdata,  0);
      tick();
      rst = 1'b0;
      drive_m1(1'b1, 1'b0, 32'h20, 32'h0);
      mid();
      check("rstmid_gnt1",      m1_gnt,    1);
      check("rstmid_rvalid0_b", m0_rvalid, 0);
      tick(); drive_m1(1'b0, 1'b0, 32'h20, 32'h0);
      mid();
      check("rstmid_rvalid1", m1_rvalid, 1);
      check("rstmid_rdata1",  m1_rdata,  32'h1);
      check("rstmid_rvalid0_c", m0_rvalid, 0);

`ifdef RAM_ARB_ADDR_CHECK_EN
      // ---------------- address range / alignment check ----------------
      tick(); drive_m0(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5);
      mid();
      check("ac_init_gnt0", m0_gnt, 1);
      tick();
      drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      drive_m1(1'b1, 1'b1, 32'h4000, 32'h12345678);
      mid();
      check("ac_wr_gnt1",   m1_gnt, 1);
      check("ac_wr_ram_we", ram_we, 0);
      tick(); drive_m1(1'b0, 1'b0, 32'h4000, 32'h0);
      mid();
      check("ac_wr_err1",    m1_err,    1);
      check("ac_wr_rvalid1", m1_rvalid, 0);
      check("ac_wr_err0",    m0_err,    0);
      check("ac_word0_kept", mem[0],    32'hA5A5A5A5);
      tick(); drive_m1(1'b1, 1'b0, 32'h11, 32'h0);
      mid();
      check("ac_rd_gnt1", m1_gnt, 1);
      tick(); drive_m1(1'b0, 1'b0, 32'h11, 32'h0);
      mid();
      check("ac_rd_rvalid1", m1_rvalid, 1);
      check("ac_rd_err1",    m1_err,    1);
      check("ac_rd_rdata1",  m1_rdata,  0);
      tick();
      mid();
      check("ac_err_pulse", m1_err, 0);
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
